// File: rtl/sid_pkg.sv
// Shared SID types and constants used by the per-voice waveform path.
package sid;

   typedef enum logic {
      MOS6581 = 1'b0,
      MOS8580 = 1'b1
   } model_e;

   localparam int unsigned PHI1      = 0;
   localparam int unsigned PHI1_PHI2 = 1;
   localparam int unsigned PHI2      = 2;
   localparam int unsigned PHI2_PHI1 = 3;

   typedef logic [3:0]  phase_t;
   typedef logic [11:0] reg12_t;
   typedef logic [19:0] reg20_t;

   // selector = {noise, pulse, sawtooth, triangle}
   typedef struct packed {
      logic [3:0] selector;
      logic [7:0] noise;
      logic       pulse;
      reg12_t     saw_tri;
   } waveform_i_t;

   localparam int unsigned TTL_6581 = 54000;
   localparam int unsigned TTL_8580 = 800000;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACTIVE,
      ST_FLOAT
   } mix_state_e;

   // One step of the floating DAC input bleeding away.
   function automatic reg12_t float_decay(input reg12_t w);
      return w & (w >> 1);
   endfunction

endpackage

// File: rtl/sid_waveform_combine.sv
// Combinational AND of the selected waveform candidates plus noise writeback enable.
module sid_waveform_combine
   import sid::*;
(
   input  waveform_i_t wav_i,
   output reg12_t      comb_o,
   output logic        wb_en_o
);

   always_comb begin
      comb_o = '1;
      if (wav_i.selector[3]) comb_o &= {wav_i.noise, 4'b0000};
      if (wav_i.selector[2]) comb_o &= {12{wav_i.pulse}};
      if (wav_i.selector[1] | wav_i.selector[0]) comb_o &= wav_i.saw_tri;
   end

   assign wb_en_o = wav_i.selector[3] & (wav_i.selector[2:0] != 3'b000);

endmodule

// File: rtl/sid_waveform_mix.sv
// Per-voice waveform mixer: combined output, OSC3 readback, noise writeback and floating-DAC decay.
module sid_waveform_mix #(
   parameter int unsigned TTL_6581 = sid::TTL_6581,
   parameter int unsigned TTL_8580 = sid::TTL_8580
) (
   input  logic             clk,
   input  logic             res,
   input  sid::model_e      model,
   input  sid::phase_t      phase,
   input  sid::waveform_i_t wav_i,
   output sid::reg12_t      wave,
   output logic [7:0]       osc3,
   output logic [7:0]       noise_wb,
   output logic             noise_wb_en
);

   if (TTL_8580 >= (1 << 20)) begin : g_chk_ttl_8580
      $error("TTL_8580 does not fit the 20-bit decay counter");
   end
   if (TTL_6581 >= (1 << 20)) begin : g_chk_ttl_6581
      $error("TTL_6581 does not fit the 20-bit decay counter");
   end

   sid::mix_state_e state_q;
   sid::reg12_t     wave_q;
   sid::reg20_t     ttl_q;
   logic [7:0]      wb_q;
   logic            wb_en_q;

   sid::reg12_t     comb_d;
   logic            wb_en_d;
   sid::reg12_t     wave_decay_d;
   sid::reg20_t     ttl_reload;
   logic            tick;
   logic            unused_phase;

   sid_waveform_combine u_combine (
      .wav_i   (wav_i),
      .comb_o  (comb_d),
      .wb_en_o (wb_en_d)
   );

   assign tick         = phase[sid::PHI1_PHI2];
   assign unused_phase = ^phase;
   assign wave_decay_d = sid::float_decay(wave_q);
   assign ttl_reload   = (model == sid::MOS8580) ? sid::reg20_t'(TTL_8580)
                                                 : sid::reg20_t'(TTL_6581);

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state_q <= sid::ST_IDLE;
         wave_q  <= '0;
         ttl_q   <= '0;
         wb_q    <= '0;
         wb_en_q <= 1'b0;
      end else if (tick) begin
         if (wav_i.selector != 4'b0000) begin
            state_q <= sid::ST_ACTIVE;
            wave_q  <= comb_d;
            ttl_q   <= ttl_reload;
            wb_q    <= comb_d[11:4];
            wb_en_q <= wb_en_d;
         end else if ((state_q != sid::ST_IDLE) && (wave_q != '0)) begin
            // Counting starts on the first unselected tick so the first decay
            // lands on the TTL-th tick after the last active one.
            state_q <= sid::ST_FLOAT;
            wb_en_q <= 1'b0;
            if (ttl_q == sid::reg20_t'(1)) begin
               wave_q <= wave_decay_d;
               ttl_q  <= ttl_reload;
               if (wave_decay_d == '0) state_q <= sid::ST_IDLE;
            end else begin
               ttl_q <= ttl_q - sid::reg20_t'(1);
            end
         end else begin
            state_q <= sid::ST_IDLE;
            ttl_q   <= '0;
         end
      end
   end

   assign wave        = wave_q;
   assign osc3        = wave_q[11:4];
   assign noise_wb    = wb_q;
   assign noise_wb_en = wb_en_q;

endmodule

// File: tb/tb_sid_waveform_mix.sv
// Scoreboard bench for sid_waveform_mix with shortened decay periods.
module tb_sid_waveform_mix;
   import sid::*;

   localparam int unsigned T6581 = 54;
   localparam int unsigned T8580 = 800;

   logic        clk = 1'b0;
   logic        res;
   model_e      model;
   phase_t      phase;
   waveform_i_t wav_i;
   reg12_t      wave;
   logic [7:0]  osc3;
   logic [7:0]  noise_wb;
   logic        noise_wb_en;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      reg12_t     wave;
      logic [7:0] osc3;
      logic [7:0] nwb;
      logic       nwb_en;
   } exp_t;

   exp_t sb[$];
   exp_t e;

   sid_waveform_mix #(
      .TTL_6581(T6581),
      .TTL_8580(T8580)
   ) dut (
      .clk         (clk),
      .res         (res),
      .model       (model),
      .phase       (phase),
      .wav_i       (wav_i),
      .wave        (wave),
      .osc3        (osc3),
      .noise_wb    (noise_wb),
      .noise_wb_en (noise_wb_en)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(input reg12_t w, input logic [7:0] nwb, input logic en);
      exp_t r;
      r.wave   = w;
      r.osc3   = w[11:4];
      r.nwb    = nwb;
      r.nwb_en = en;
      return r;
   endfunction

   task automatic set_wav(input logic [3:0] sel, input logic [7:0] nz, input logic pl, input reg12_t st);
      wav_i.selector = sel;
      wav_i.noise    = nz;
      wav_i.pulse    = pl;
      wav_i.saw_tri  = st;
   endtask

   // One non-tick edge (inputs already applied) followed by one tick edge.
   task automatic tick();
      @(negedge clk);
      phase = '0;
      @(posedge clk);
      @(negedge clk);
      phase = '0;
      phase[PHI1_PHI2] = 1'b1;
      @(posedge clk);
      #1;
      phase = '0;
   endtask

   task automatic test_reset();
      res   = 1'b0;
      phase = '0;
      model = MOS6581;
      wav_i = '0;
      #1 res = 1'b1;
      #1;
      checks++;
      if ({wave, osc3, noise_wb, noise_wb_en} !== 29'd0) begin
         errors++;
         $display("FAIL reset: got wave=%h osc3=%h nwb=%h en=%b, want all zero",
                  wave, osc3, noise_wb, noise_wb_en);
      end
      set_wav(4'b0010, 8'h00, 1'b0, 12'hABC);
      @(negedge clk);
      #2 res = 1'b0;
      sb.push_back(mk(12'h000, 8'h00, 1'b0));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if ({wave, osc3, noise_wb, noise_wb_en} !== e) begin
         errors++;
         $display("FAIL reset_release_no_tick: got wave=%h osc3=%h nwb=%h en=%b, want wave=%h osc3=%h nwb=%h en=%b",
                  wave, osc3, noise_wb, noise_wb_en, e.wave, e.osc3, e.nwb, e.nwb_en);
      end
   endtask

   task automatic test_saw();
      set_wav(4'b0010, 8'h00, 1'b0, 12'hABC);
      sb.push_back(mk(12'hABC, 8'hAB, 1'b0));
      tick();
      e = sb.pop_front();
      checks++;
      if ({wave, osc3, noise_wb, noise_wb_en} !== e) begin
         errors++;
         $display("FAIL saw_only: got wave=%h osc3=%h nwb=%h en=%b, want wave=%h osc3=%h nwb=%h en=%b",
                  wave, osc3, noise_wb, noise_wb_en, e.wave, e.osc3, e.nwb, e.nwb_en);
      end
   endtask

   task automatic test_saw_pulse();
      for (int i = 0; i < 2; i++) begin
         set_wav(4'b0110, 8'h00, (i == 1), 12'hFFF);
         sb.push_back((i == 1) ? mk(12'hFFF, 8'hFF, 1'b0) : mk(12'h000, 8'h00, 1'b0));
         tick();
         e = sb.pop_front();
         checks++;
         if ({wave, osc3, noise_wb, noise_wb_en} !== e) begin
            errors++;
            $display("FAIL saw_pulse step=%0d: got wave=%h osc3=%h nwb=%h en=%b, want wave=%h osc3=%h nwb=%h en=%b",
                     i, wave, osc3, noise_wb, noise_wb_en, e.wave, e.osc3, e.nwb, e.nwb_en);
         end
      end
   endtask

   task automatic test_noise_mix();
      logic [3:0] sel_t [3]  = '{4'b1100, 4'b1011, 4'b1000};
      logic [7:0] nz_t  [3]  = '{8'h5A,   8'hFF,   8'h3C};
      reg12_t     st_t  [3]  = '{12'h000, 12'h0F0, 12'hFFF};
      exp_t       ex_t  [3];
      ex_t[0] = mk(12'h5A0, 8'h5A, 1'b1);
      ex_t[1] = mk(12'h0F0, 8'h0F, 1'b1);
      ex_t[2] = mk(12'h3C0, 8'h3C, 1'b0);
      for (int i = 0; i < 3; i++) begin
         set_wav(sel_t[i], nz_t[i], 1'b1, st_t[i]);
         sb.push_back(ex_t[i]);
         tick();
         e = sb.pop_front();
         checks++;
         if ({wave, osc3, noise_wb, noise_wb_en} !== e) begin
            errors++;
            $display("FAIL noise_mix case=%0d: got wave=%h osc3=%h nwb=%h en=%b, want wave=%h osc3=%h nwb=%h en=%b",
                     i, wave, osc3, noise_wb, noise_wb_en, e.wave, e.osc3, e.nwb, e.nwb_en);
         end
      end
   endtask

   task automatic test_float_6581();
      reg12_t dec_t [9] = '{12'hFF0, 12'h7F0, 12'h3F0, 12'h1F0, 12'h0F0,
                            12'h070, 12'h030, 12'h010, 12'h000};
      int unsigned idx;
      model = MOS6581;
      set_wav(4'b0010, 8'h00, 1'b0, 12'hFF0);
      sb.push_back(mk(12'hFF0, 8'hFF, 1'b0));
      tick();
      set_wav(4'b0000, 8'h00, 1'b0, 12'hFF0);
      for (int unsigned k = 0; k <= 8 * T6581 + 3; k++) begin
         if (k > 0) begin
            idx = k / T6581;
            if (idx > 8) idx = 8;
            sb.push_back(mk(dec_t[idx], 8'hFF, 1'b0));
            tick();
         end
         e = sb.pop_front();
         checks++;
         if ({wave, osc3, noise_wb, noise_wb_en} !== e) begin
            errors++;
            $display("FAIL float6581 tick=%0d: got wave=%h osc3=%h nwb=%h en=%b, want wave=%h osc3=%h nwb=%h en=%b",
                     k, wave, osc3, noise_wb, noise_wb_en, e.wave, e.osc3, e.nwb, e.nwb_en);
         end
      end
   endtask

   task automatic test_float_8580();
      model = MOS8580;
      set_wav(4'b0010, 8'h00, 1'b0, 12'h800);
      sb.push_back(mk(12'h800, 8'h80, 1'b0));
      tick();
      set_wav(4'b0000, 8'h00, 1'b0, 12'h800);
      for (int unsigned k = 0; k <= T8580 + 2; k++) begin
         if (k > 0) begin
            sb.push_back(mk((k < T8580) ? 12'h800 : 12'h000, 8'h80, 1'b0));
            tick();
         end
         e = sb.pop_front();
         checks++;
         if ({wave, osc3, noise_wb, noise_wb_en} !== e) begin
            errors++;
            $display("FAIL float8580 tick=%0d: got wave=%h osc3=%h nwb=%h en=%b, want wave=%h osc3=%h nwb=%h en=%b",
                     k, wave, osc3, noise_wb, noise_wb_en, e.wave, e.osc3, e.nwb, e.nwb_en);
         end
      end
   endtask

   task automatic test_reset_in_float();
      model = MOS6581;
      set_wav(4'b0010, 8'h00, 1'b0, 12'hF00);
      sb.push_back(mk(12'hF00, 8'hF0, 1'b0));
      tick();
      set_wav(4'b0000, 8'h00, 1'b0, 12'hF00);
      for (int k = 0; k <= 10; k++) begin
         if (k > 0) begin
            sb.push_back(mk(12'hF00, 8'hF0, 1'b0));
            tick();
         end
         e = sb.pop_front();
         checks++;
         if ({wave, osc3, noise_wb, noise_wb_en} !== e) begin
            errors++;
            $display("FAIL pre_reset_float tick=%0d: got wave=%h osc3=%h nwb=%h en=%b, want wave=%h osc3=%h nwb=%h en=%b",
                     k, wave, osc3, noise_wb, noise_wb_en, e.wave, e.osc3, e.nwb, e.nwb_en);
         end
      end
      @(negedge clk);
      #2 res = 1'b1;
      #1;
      checks++;
      if ({wave, osc3, noise_wb, noise_wb_en} !== 29'd0) begin
         errors++;
         $display("FAIL reset_mid_float: got wave=%h osc3=%h nwb=%h en=%b, want all zero",
                  wave, osc3, noise_wb, noise_wb_en);
      end
      #1 res = 1'b0;
      sb.push_back(mk(12'h000, 8'h00, 1'b0));
      tick();
      e = sb.pop_front();
      checks++;
      if ({wave, osc3, noise_wb, noise_wb_en} !== e) begin
         errors++;
         $display("FAIL post_reset_idle: got wave=%h osc3=%h nwb=%h en=%b, want wave=%h osc3=%h nwb=%h en=%b",
                  wave, osc3, noise_wb, noise_wb_en, e.wave, e.osc3, e.nwb, e.nwb_en);
      end
   endtask

   task automatic test_reenable_on_decay();
      model = MOS6581;
      set_wav(4'b0010, 8'h00, 1'b0, 12'h0F0);
      sb.push_back(mk(12'h0F0, 8'h0F, 1'b0));
      tick();
      e = sb.pop_front();
      set_wav(4'b0000, 8'h00, 1'b0, 12'h0F0);
      for (int unsigned k = 1; k <= T6581; k++) begin
         if (k == T6581) begin
            set_wav(4'b0010, 8'h00, 1'b0, 12'h123);
            sb.push_back(mk(12'h123, 8'h12, 1'b0));
         end else begin
            sb.push_back(mk(12'h0F0, 8'h0F, 1'b0));
         end
         tick();
         e = sb.pop_front();
         if (k == T6581 || k == T6581 - 1) begin
            checks++;
            if ({wave, osc3, noise_wb, noise_wb_en} !== e) begin
               errors++;
               $display("FAIL reenable_on_decay tick=%0d: got wave=%h osc3=%h nwb=%h en=%b, want wave=%h osc3=%h nwb=%h en=%b",
                        k, wave, osc3, noise_wb, noise_wb_en, e.wave, e.osc3, e.nwb, e.nwb_en);
            end
         end
      end
      set_wav(4'b0000, 8'h00, 1'b0, 12'h123);
      for (int unsigned k = 1; k <= T6581; k++) begin
         sb.push_back(mk((k < T6581) ? 12'h123 : 12'h001, 8'h12, 1'b0));
         tick();
         e = sb.pop_front();
         if (k >= T6581 - 1) begin
            checks++;
            if ({wave, osc3, noise_wb, noise_wb_en} !== e) begin
               errors++;
               $display("FAIL ttl_reload tick=%0d: got wave=%h osc3=%h nwb=%h en=%b, want wave=%h osc3=%h nwb=%h en=%b",
                        k, wave, osc3, noise_wb, noise_wb_en, e.wave, e.osc3, e.nwb, e.nwb_en);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_saw();
      test_saw_pulse();
      test_noise_mix();
      test_float_6581();
      test_float_8580();
      test_reset_in_float();
      test_reenable_on_decay();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sid_waveform_mix.md
# sid_waveform_mix

Combines the per-voice waveform generator outputs (selector, noise, pulse, sawtooth/triangle) into the 12-bit waveform value that feeds the voice DAC. It captures the upper 8 bits as the OSC3 readback value and returns combined-waveform bits for noise LFSR writeback. It also models the floating DAC input: when no waveform is selected, the last value is held and then decays. It sits directly downstream of the waveform generator, one instance per voice.

## Interface
- `TTL_6581`, default 54000: SID cycles between decay steps of the floating output for the 6581.
- `TTL_8580`, default 800000: SID cycles between decay steps of the floating output for the 8580.
- `clk`  in  1: system clock.
- `res`  in  1: reset, asynchronous, active-high.
- `model`  in  `sid::model_e`: MOS6581 or MOS8580.
- `phase`  in  `sid::phase_t`: phase strobes. Only `phase[sid::PHI1_PHI2]` ("tick", one per SID cycle) is used.
- `wav_i`  in  `sid::waveform_i_t`: selector[3:0] = {noise, pulse, sawtooth, triangle}, noise[7:0], pulse, saw_tri[11:0].
- `wave`  out  12: combined waveform value to the DAC.
- `osc3`  out  8: `wave[11:4]`, for the OSC3 register read at phi2.
- `noise_wb`  out  8: combined bits to write back into the noise LFSR taps.
- `noise_wb_en`  out  1: writeback request.

## Operation
- Candidate waveform values:
  - N = {noise[7:0], 4'b0}
  - P = {12{pulse}}
  - T = saw_tri
- Combined value C is the bitwise AND of the candidates whose selector bit is set.
  - Sawtooth and triangle share T.
  - Sawtooth + triangle = T.
- State machine, evaluated only on tick:
  - ACTIVE (selector != 0):
    - wave <= C.
    - ttl <= TTL(model).
    - noise_wb_en <= selector[3] & (selector[2:0] != 0).
    - noise_wb <= C[11:4].
  - FLOAT (selector == 0, wave != 0):
    - noise_wb_en <= 0; wave is held.
    - If ttl == 1: wave <= wave & (wave >> 1), and ttl <= TTL(model).
    - Otherwise: ttl <= ttl − 1.
  - IDLE (selector == 0, wave == 0): ttl <= 0; all outputs hold.
- Transitions:
  - Any state goes to ACTIVE as soon as selector != 0 at a tick.
  - From ACTIVE, selector == 0 goes to FLOAT if wave != 0, else IDLE.
  - From FLOAT, a decay reaching 0 goes to IDLE.
- ttl is 20 bits wide. TTL_8580 must be < 2^20 (elaboration check).
- A model change during FLOAT takes effect at the next reload only; the current count is not altered.
- osc3 is purely wave[11:4] (combinational from the register).

## Timing
- On assertion of res, immediately: wave = 0, osc3 = 0, noise_wb = 0, noise_wb_en = 0, ttl = 0, state IDLE.
- Latency: inputs are sampled at the tick edge. wave, osc3 and noise_wb are valid from that edge until the next tick.
- Upstream timing: saw_tri and pulse have already settled for the cycle (PHI1 / PHI2_PHI1 upstream). Each mix therefore reflects the current cycle's saw_tri and the pulse comparison of the previous cycle, with no further delay.
- noise_wb_en is a level, one SID cycle per tick. Upstream consumes it at its next noise update; no handshake back.
- Decay timing in FLOAT:
  - The first decay happens on the TTL-th tick after the last ACTIVE tick.
  - Subsequent decays happen every TTL ticks.
  - A 12-bit value reaches 0 in at most 12 decays.
- Selector re-enabled on the same tick as a decay: ACTIVE wins. wave <= C, and the decay is discarded.
- Reset released mid-cycle: nothing changes until the first tick after release.
- Non-tick edges change no state.

## Structure
- Shared `sid` package:
  - `TTL_6581` and `TTL_8580` constants (parameters default to these).
  - `reg20_t` (ttl).
  - Reuses existing `model_e`, `phase_t`, `waveform_i_t`, `reg12_t`.
- One sub-module, `sid_waveform_combine`: purely combinational candidate selection / AND producing C and the writeback enable.
- The FSM and ttl counter live in the top.

## Test plan
- Sawtooth only, saw_tri = 12'hABC, tick → wave = 12'hABC, osc3 = 8'hAB, noise_wb_en = 0.
- Sawtooth + pulse, saw_tri = 12'hFFF:
  - pulse = 0 → wave = 0.
  - Next tick with pulse = 1 → wave = 12'hFFF.
- Noise + pulse, noise = 8'h5A, pulse = 1 → wave = 12'h5A0, noise_wb = 8'h5A, noise_wb_en = 1.
- 6581 float, wave = 12'hFF0, selector → 0:
  - Held 12'hFF0 through tick 53999.
  - 12'h7F0 at tick 54000.
  - 12'h3F0 at tick 108000.
  - 0 after 8 decays, then IDLE.
- 8580 float from 12'h800: held until tick 800000, then 0.
- Interruptions during float:
  - res asserted mid-FLOAT → outputs 0 immediately, without waiting for a tick.
  - Separately, selector re-enabled on a decay tick → wave = new C, and ttl reloads to TTL.
